cfg_mgmt_to_cct1_completion: RTL and testbench
==============================================

// Module: cfg_mgmt_to_cct1_completion
// PURPOSE
//  Return path for Type 1 config requests that the switch terminates locally on the DSP cfg_mgmt port.
//  Captures the qualifying CQ descriptor and waits for cfg_mgmt_read_write_done (or a timeout).
//  Then drives one completer-completion (CC) beat back on the DSP AXI-S CC interface, as Cpl or CplD.
// PARAMETERS
//  DSP_IF_WIDTH        512   CC/CQ tdata width
//  DSP_TKEEP_WIDTH     16    per-DW tkeep width
//  DSP_CQ_TUSER_WIDTH  231   CQ tuser width
//  DSP_CC_TUSER_WIDTH  81    CC tuser width
//  TIMEOUT_CYCLES      1024  cycles waited for done before an error completion is generated
//  COMPLETER_ID        16'h0 completer ID placed in descriptor [87:72]
// PORTS
//  user_clk                  in   1    clock
//  user_reset_n              in   1    asynchronous, active-low reset
//  dsp_m_axis_cq_tdata       in   DSP_IF_WIDTH        CQ beat (descriptor in [127:0])
//  dsp_m_axis_cq_tuser       in   DSP_CQ_TUSER_WIDTH  CQ sideband (unused except for qualification)
//  dsp_m_axis_cq_tvalid      in   1    CQ beat valid
//  select                    in   2    routing select; 2'b01 = local cfg space
//  req_type                  in   4    CQ request type (copy of descriptor [78:75])
//  cfg_mgmt_read_data        in   32   cfg_mgmt read return
//  cfg_mgmt_read_write_done  in   1    cfg_mgmt access complete
//  dsp_s_axis_cc_tdata       out  DSP_IF_WIDTH        completion beat
//  dsp_s_axis_cc_tkeep       out  DSP_TKEEP_WIDTH     DW enables
//  dsp_s_axis_cc_tlast       out  1    always 1 while tvalid
//  dsp_s_axis_cc_tuser       out  DSP_CC_TUSER_WIDTH  all zero
//  dsp_s_axis_cc_tvalid      out  1    completion valid
//  dsp_s_axis_cc_tready      in   1    sink ready
//  cq_req_done               out  1    1-cycle pulse: request finished, upstream drops CQ beat
//  busy                      out  1    state != IDLE
// BEHAVIOUR
//  Qualify: tvalid & req_type[3:2]==2'b10 & select==2'b01 & tdata[111:104]==8'h00.
//  Reset: all outputs 0 and state IDLE. Async assert clears tvalid immediately, including mid-SEND; no partial beat replays.
//  FSM IDLE -> WAIT_DONE -> SEND -> IDLE.
//   IDLE: on qualify, latch requester ID [95:80], tag [103:96], TC [123:121], attr [126:124],
//     and is_write=req_type[1]. Clear the timeout counter.
//     If done is high in the same cycle, latch read data and go directly to SEND. Otherwise go to WAIT_DONE.
//   WAIT_DONE: counter increments each cycle. On done, latch cfg_mgmt_read_data, status=SC(3'b000), go to SEND.
//     When the counter reaches TIMEOUT_CYCLES-1 without done: status=UR(3'b001), data=0, go to SEND.
//     If done and timeout occur in the same cycle, done wins.
//   The transition out of IDLE/WAIT_DONE that enters SEND also pulses cq_req_done.
//   SEND: tvalid=1; tdata/tkeep/tuser held stable until tvalid&tready, then go to IDLE.
//     Qualifying CQ beats outside IDLE are ignored; upstream honours busy.
//  CC descriptor (remaining bits 0):
//   [6:0] lower addr = 0 (config completion).
//   [28:16] byte count = 4.
//   [42:32] DW count = 1 for a read with SC, otherwise 0.
//   [45:43] status. [63:48] requester ID. [71:64] tag. [87:72] COMPLETER_ID. [88] = 1.
//   [91:89] TC. [94:92] attr.
//   [127:96] read data (read with SC only).
//  tkeep: 16'h000F when a data DW is present, otherwise 16'h0007.
//  Latency: from done at edge N, tvalid is high after edge N+1. Minimum spacing is 3 cycles per request.
// STRUCTURE
//  cpm5_switch_pkg: typedef struct packed cc_desc_t (96 b); localparams CPL_SC/CPL_UR/CPL_CRS;
//   enum cfgcpl_state_e; function pack_cc_desc().
//  Single module, no sub-module; FSM and timeout counter ($clog2(TIMEOUT_CYCLES) bits) are inline.
// TESTING
//  1 Read: req_type 4'b1000, reqID 16'h0100, tag 8'h2A, done+data 32'hDEADBEEF after 5 cycles
//    -> CC [127:96]=DEADBEEF, DWcnt=1, bytecnt=4, status=000, tag=2A, tkeep=000F, tlast=1.
//  2 Write: req_type 4'b1010, TC 3'd2, attr 3'b010, done after 2 cycles
//    -> DWcnt=0, tkeep=0007, [91:89]=2, [94:92]=010, one cq_req_done pulse.
//  3 Timeout: no done for TIMEOUT_CYCLES -> status=001, DWcnt=0, tkeep=0007, data 0; done arriving later ignored.
//  4 Backpressure: tready low 10 cycles in SEND -> tvalid held, tdata stable, busy=1;
//    a second CQ presented meanwhile is not captured.
//  5 Same-cycle capture+done at edge N -> tvalid=1 after N+1, cq_req_done pulses once.
//    Non-qualifying CQ (select=2'b10 or function 8'h01) -> no completion.
//  6 Reset asserted mid-WAIT_DONE and mid-SEND -> tvalid/busy 0 immediately; next read completes normally.

Source files
------------

// File: rtl/cpm5_switch_pkg.sv
// Shared types for the local config-completion return path: CC descriptor
// layout, completion status codes, FSM state encoding and a descriptor packer.
package cpm5_switch_pkg;

  localparam logic [2:0] CPL_SC  = 3'b000;
  localparam logic [2:0] CPL_UR  = 3'b001;
  localparam logic [2:0] CPL_CRS = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DONE = 2'd1,
    ST_SEND      = 2'd2
  } cfgcpl_state_e;

  // Lower 96 bits of the CC descriptor, MSB first.
  typedef struct packed {
    logic        rsvd95;
    logic [2:0]  attr;
    logic [2:0]  tc;
    logic        cpl_id_en;
    logic [15:0] completer_id;
    logic [7:0]  tag;
    logic [15:0] requester_id;
    logic [1:0]  rsvd47;
    logic [2:0]  status;
    logic [10:0] dw_count;
    logic [2:0]  rsvd31;
    logic [12:0] byte_count;
    logic [8:0]  rsvd15;
    logic [6:0]  lower_addr;
  } cc_desc_t;

  // Config completions always report a 4-byte count at lower address 0;
  // only a successful read carries a payload DW.
  function automatic cc_desc_t pack_cc_desc(
    input logic [15:0] requester_id,
    input logic [7:0]  tag,
    input logic [2:0]  tc,
    input logic [2:0]  attr,
    input logic [2:0]  status,
    input logic        has_data,
    input logic [15:0] completer_id
  );
    cc_desc_t d;
    d              = '0;
    d.lower_addr   = 7'd0;
    d.byte_count   = 13'd4;
    d.dw_count     = has_data ? 11'd1 : 11'd0;
    d.status       = status;
    d.requester_id = requester_id;
    d.tag          = tag;
    d.completer_id = completer_id;
    d.cpl_id_en    = 1'b1;
    d.tc           = tc;
    d.attr         = attr;
    return d;
  endfunction

endpackage

// File: rtl/cfg_mgmt_to_cct1_completion.sv
// Local Type 1 config return path: captures a qualifying CQ descriptor, waits
// for cfg_mgmt done (or a timeout) and emits one CC beat as Cpl or CplD.
//
// state     | meaning
// ST_IDLE   | waiting for a qualifying CQ beat
// ST_WAIT_DONE | request captured, waiting for cfg_mgmt done or timeout
// ST_SEND   | CC beat valid, held until accepted
module cfg_mgmt_to_cct1_completion
  import cpm5_switch_pkg::*;
#(
  parameter int          DSP_IF_WIDTH       = 512,
  parameter int          DSP_TKEEP_WIDTH    = 16,
  parameter int          DSP_CQ_TUSER_WIDTH = 231,
  parameter int          DSP_CC_TUSER_WIDTH = 81,
  parameter int          TIMEOUT_CYCLES     = 1024,
  parameter logic [15:0] COMPLETER_ID       = 16'h0
) (
  input  logic                          user_clk,
  input  logic                          user_reset_n,
  input  logic [DSP_IF_WIDTH-1:0]       dsp_m_axis_cq_tdata,
  input  logic [DSP_CQ_TUSER_WIDTH-1:0] dsp_m_axis_cq_tuser,
  input  logic                          dsp_m_axis_cq_tvalid,
  input  logic [1:0]                    select,
  input  logic [3:0]                    req_type,
  input  logic [31:0]                   cfg_mgmt_read_data,
  input  logic                          cfg_mgmt_read_write_done,
  output logic [DSP_IF_WIDTH-1:0]       dsp_s_axis_cc_tdata,
  output logic [DSP_TKEEP_WIDTH-1:0]    dsp_s_axis_cc_tkeep,
  output logic                          dsp_s_axis_cc_tlast,
  output logic [DSP_CC_TUSER_WIDTH-1:0] dsp_s_axis_cc_tuser,
  output logic                          dsp_s_axis_cc_tvalid,
  input  logic                          dsp_s_axis_cc_tready,
  output logic                          cq_req_done,
  output logic                          busy
);

  localparam int             TCW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT_CYCLES - 1);

  cfgcpl_state_e  state_q, state_d;
  logic [15:0]    req_id_q, req_id_d;
  logic [7:0]     tag_q, tag_d;
  logic [2:0]     tc_q, tc_d;
  logic [2:0]     attr_q, attr_d;
  logic           is_write_q, is_write_d;
  logic [2:0]     status_q, status_d;
  logic [31:0]    rdata_q, rdata_d;
  logic [TCW-1:0] cnt_q, cnt_d;
  logic           cq_done_q;
  logic           cq_qualify, timeout_hit, has_data;
  cc_desc_t       cc_desc;
  logic           unused_cq;

  assign cq_qualify  = dsp_m_axis_cq_tvalid && (req_type[3:2] == 2'b10) &&
                       (select == 2'b01) && (dsp_m_axis_cq_tdata[111:104] == 8'h00);
  assign timeout_hit = (cnt_q == TO_LAST);
  assign has_data    = !is_write_q && (status_q == CPL_SC);
  assign cc_desc     = pack_cc_desc(req_id_q, tag_q, tc_q, attr_q, status_q, has_data, COMPLETER_ID);
  assign unused_cq   = ^{dsp_m_axis_cq_tuser, dsp_m_axis_cq_tdata[DSP_IF_WIDTH-1:127],
                         dsp_m_axis_cq_tdata[120:112], dsp_m_axis_cq_tdata[79:0], req_type[0]};

  // State register; async reset drops tvalid at once, even mid-beat.
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) state_q <= ST_IDLE;
    else               state_q <= state_d;
  end

  // Next state; done takes priority over a coincident timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (cq_qualify) state_d = cfg_mgmt_read_write_done ? ST_SEND : ST_WAIT_DONE;
      ST_WAIT_DONE: if (cfg_mgmt_read_write_done || timeout_hit) state_d = ST_SEND;
      ST_SEND:      if (dsp_s_axis_cc_tready) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Request capture, completion status/data and timeout counter next values.
  always_comb begin
    req_id_d   = req_id_q;
    tag_d      = tag_q;
    tc_d       = tc_q;
    attr_d     = attr_q;
    is_write_d = is_write_q;
    status_d   = status_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cq_qualify) begin
          req_id_d   = dsp_m_axis_cq_tdata[95:80];
          tag_d      = dsp_m_axis_cq_tdata[103:96];
          tc_d       = dsp_m_axis_cq_tdata[123:121];
          attr_d     = dsp_m_axis_cq_tdata[126:124];
          is_write_d = req_type[1];
          cnt_d      = '0;
          if (cfg_mgmt_read_write_done) begin
            status_d = CPL_SC;
            rdata_d  = cfg_mgmt_read_data;
          end
        end
      end
      ST_WAIT_DONE: begin
        cnt_d = cnt_q + TCW'(1);
        if (cfg_mgmt_read_write_done) begin
          status_d = CPL_SC;
          rdata_d  = cfg_mgmt_read_data;
        end else if (timeout_hit) begin
          status_d = CPL_UR;
          rdata_d  = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers and the one-cycle request-finished pulse.
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      req_id_q   <= '0;
      tag_q      <= '0;
      tc_q       <= '0;
      attr_q     <= '0;
      is_write_q <= 1'b0;
      status_q   <= CPL_SC;
      rdata_q    <= '0;
      cnt_q      <= '0;
      cq_done_q  <= 1'b0;
    end else begin
      req_id_q   <= req_id_d;
      tag_q      <= tag_d;
      tc_q       <= tc_d;
      attr_q     <= attr_d;
      is_write_q <= is_write_d;
      status_q   <= status_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      cq_done_q  <= (state_q != ST_SEND) && (state_d == ST_SEND);
    end
  end

  // CC beat is driven from held registers only while in SEND, so it stays stable under backpressure.
  always_comb begin
    dsp_s_axis_cc_tdata  = '0;
    dsp_s_axis_cc_tkeep  = '0;
    dsp_s_axis_cc_tlast  = 1'b0;
    dsp_s_axis_cc_tuser  = '0;
    dsp_s_axis_cc_tvalid = 1'b0;
    if (state_q == ST_SEND) begin
      dsp_s_axis_cc_tvalid       = 1'b1;
      dsp_s_axis_cc_tlast        = 1'b1;
      dsp_s_axis_cc_tdata[95:0]  = cc_desc;
      dsp_s_axis_cc_tdata[127:96] = has_data ? rdata_q : 32'h0;
      dsp_s_axis_cc_tkeep        = has_data ? DSP_TKEEP_WIDTH'(16'h000F) : DSP_TKEEP_WIDTH'(16'h0007);
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign cq_req_done = cq_done_q;

endmodule

// File: tb/tb_cfg_mgmt_to_cct1_completion.sv
module tb_cfg_mgmt_to_cct1_completion;

  localparam int W  = 512;
  localparam int KW = 16;
  localparam int QU = 231;
  localparam int CU = 81;

  logic          user_clk = 1'b0;
  logic          user_reset_n;
  logic [W-1:0]  cq_tdata;
  logic [QU-1:0] cq_tuser;
  logic          cq_tvalid;
  logic [1:0]    select;
  logic [3:0]    req_type;
  logic [31:0]   rd_data;
  logic          done;
  logic [W-1:0]  cc_tdata;
  logic [KW-1:0] cc_tkeep;
  logic          cc_tlast;
  logic [CU-1:0] cc_tuser;
  logic          cc_tvalid;
  logic          cc_tready;
  logic          cq_req_done;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;
  int pulse_cnt = 0;

  cfg_mgmt_to_cct1_completion dut (
    .user_clk                 (user_clk),
    .user_reset_n             (user_reset_n),
    .dsp_m_axis_cq_tdata      (cq_tdata),
    .dsp_m_axis_cq_tuser      (cq_tuser),
    .dsp_m_axis_cq_tvalid     (cq_tvalid),
    .select                   (select),
    .req_type                 (req_type),
    .cfg_mgmt_read_data       (rd_data),
    .cfg_mgmt_read_write_done (done),
    .dsp_s_axis_cc_tdata      (cc_tdata),
    .dsp_s_axis_cc_tkeep      (cc_tkeep),
    .dsp_s_axis_cc_tlast      (cc_tlast),
    .dsp_s_axis_cc_tuser      (cc_tuser),
    .dsp_s_axis_cc_tvalid     (cc_tvalid),
    .dsp_s_axis_cc_tready     (cc_tready),
    .cq_req_done              (cq_req_done),
    .busy                     (busy)
  );

  always #5 user_clk = ~user_clk;

  // Count cq_req_done pulses a little after each rising edge.
  always @(posedge user_clk) begin
    #2;
    if (user_reset_n && cq_req_done) pulse_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1);
  end

  function automatic logic [W-1:0] exp_cc(input logic [15:0] rid, input logic [7:0] tag,
                                          input logic [2:0] tc, input logic [2:0] attr,
                                          input logic [2:0] st, input logic has_data,
                                          input logic [31:0] data);
    logic [W-1:0] d;
    d = '0;
    d[28:16] = 13'd4;
    d[42:32] = has_data ? 11'd1 : 11'd0;
    d[45:43] = st;
    d[63:48] = rid;
    d[71:64] = tag;
    d[87:72] = 16'h0000;
    d[88]    = 1'b1;
    d[91:89] = tc;
    d[94:92] = attr;
    if (has_data) d[127:96] = data;
    return d;
  endfunction

  task automatic cq_set(input logic [15:0] rid, input logic [7:0] tag, input logic [2:0] tc,
                        input logic [2:0] attr, input logic [3:0] rtype, input logic [1:0] sel,
                        input logic [7:0] func);
    logic [W-1:0] d;
    d = '0;
    d[W-1:128] = '1;
    d[63:0]    = 64'h0123_4567_89AB_CDEF;
    d[78:75]   = rtype;
    d[95:80]   = rid;
    d[103:96]  = tag;
    d[111:104] = func;
    d[123:121] = tc;
    d[126:124] = attr;
    cq_tdata  = d;
    req_type  = rtype;
    select    = sel;
    cq_tvalid = 1'b1;
  endtask

  task automatic accept_beat();
    cc_tready = 1'b1;
    @(negedge user_clk);
    cc_tready = 1'b0;
  endtask

  task automatic test_reset();
    user_reset_n = 1'b0;
    cq_tdata = '0; cq_tuser = '0; cq_tvalid = 1'b0; select = 2'b00; req_type = 4'h0;
    rd_data = '0; done = 1'b0; cc_tready = 1'b0;
    repeat (3) @(negedge user_clk);
    n_checks++;
    if (cc_tvalid !== 1'b0 || busy !== 1'b0 || cq_req_done !== 1'b0)
      $display("FAIL reset_ctrl: tvalid=%b busy=%b cq_req_done=%b, required 0/0/0", cc_tvalid, busy, cq_req_done);
    else n_pass++;
    n_checks++;
    if (cc_tdata !== '0 || cc_tkeep !== '0 || cc_tlast !== 1'b0 || cc_tuser !== '0)
      $display("FAIL reset_data: tdata[127:0]=%h tkeep=%h tlast=%b, required all zero", cc_tdata[127:0], cc_tkeep, cc_tlast);
    else n_pass++;
    user_reset_n = 1'b1;
    @(negedge user_clk);
  endtask

  task automatic test_read();
    logic [W-1:0] e;
    int p0;
    p0 = pulse_cnt;
    e = exp_cc(16'h0100, 8'h2A, 3'd0, 3'd0, 3'b000, 1'b1, 32'hDEADBEEF);
    cq_set(16'h0100, 8'h2A, 3'd0, 3'd0, 4'b1000, 2'b01, 8'h00);
    @(negedge user_clk);
    n_checks++;
    if (busy !== 1'b1 || cc_tvalid !== 1'b0)
      $display("FAIL read_wait: busy=%b tvalid=%b, required 1/0", busy, cc_tvalid);
    else n_pass++;
    repeat (3) @(negedge user_clk);
    done = 1'b1; rd_data = 32'hDEADBEEF;
    @(negedge user_clk);
    done = 1'b0; rd_data = 32'h0; cq_tvalid = 1'b0;
    n_checks++;
    if (cc_tvalid !== 1'b1) $display("FAIL read_tvalid: got %b, required 1", cc_tvalid);
    else n_pass++;
    n_checks++;
    if (cc_tdata !== e) $display("FAIL read_tdata: got %h, required %h", cc_tdata[127:0], e[127:0]);
    else n_pass++;
    n_checks++;
    if (cc_tkeep !== 16'h000F || cc_tlast !== 1'b1 || cc_tuser !== '0)
      $display("FAIL read_sideband: tkeep=%h tlast=%b, required 000f/1 tuser 0", cc_tkeep, cc_tlast);
    else n_pass++;
    n_checks++;
    if (pulse_cnt - p0 !== 1) $display("FAIL read_pulse: got %0d pulses, required 1", pulse_cnt - p0);
    else n_pass++;
    accept_beat();
    n_checks++;
    if (cc_tvalid !== 1'b0 || busy !== 1'b0)
      $display("FAIL read_release: tvalid=%b busy=%b, required 0/0", cc_tvalid, busy);
    else n_pass++;
  endtask

  task automatic test_write();
    logic [W-1:0] e;
    int p0;
    p0 = pulse_cnt;
    e = exp_cc(16'h0203, 8'h11, 3'd2, 3'b010, 3'b000, 1'b0, 32'h0);
    rd_data = 32'hCAFEF00D;
    cq_set(16'h0203, 8'h11, 3'd2, 3'b010, 4'b1010, 2'b01, 8'h00);
    @(negedge user_clk);
    cq_tvalid = 1'b0;
    @(negedge user_clk);
    done = 1'b1;
    @(negedge user_clk);
    done = 1'b0;
    n_checks++;
    if (cc_tvalid !== 1'b1 || cc_tdata !== e)
      $display("FAIL write_tdata: tvalid=%b got %h, required 1 %h", cc_tvalid, cc_tdata[127:0], e[127:0]);
    else n_pass++;
    n_checks++;
    if (cc_tkeep !== 16'h0007) $display("FAIL write_tkeep: got %h, required 0007", cc_tkeep);
    else n_pass++;
    n_checks++;
    if (cc_tdata[91:89] !== 3'd2 || cc_tdata[94:92] !== 3'b010)
      $display("FAIL write_tc_attr: tc=%0d attr=%b, required 2/010", cc_tdata[91:89], cc_tdata[94:92]);
    else n_pass++;
    @(negedge user_clk);
    n_checks++;
    if (pulse_cnt - p0 !== 1) $display("FAIL write_pulse: got %0d pulses, required 1", pulse_cnt - p0);
    else n_pass++;
    accept_beat();
    rd_data = 32'h0;
  endtask

  task automatic test_timeout();
    logic [W-1:0] e;
    logic early;
    int p0;
    p0 = pulse_cnt;
    early = 1'b0;
    e = exp_cc(16'h0A0B, 8'h5C, 3'd1, 3'b001, 3'b001, 1'b0, 32'h0);
    rd_data = 32'h11112222;
    cq_set(16'h0A0B, 8'h5C, 3'd1, 3'b001, 4'b1000, 2'b01, 8'h00);
    @(negedge user_clk);
    cq_tvalid = 1'b0;
    if (cc_tvalid) early = 1'b1;
    repeat (1023) begin
      @(negedge user_clk);
      if (cc_tvalid) early = 1'b1;
    end
    n_checks++;
    if (early !== 1'b0 || busy !== 1'b1)
      $display("FAIL timeout_early: early_tvalid=%b busy=%b, required 0/1", early, busy);
    else n_pass++;
    @(negedge user_clk);
    n_checks++;
    if (cc_tvalid !== 1'b1 || cc_tdata !== e)
      $display("FAIL timeout_tdata: tvalid=%b got %h, required 1 %h", cc_tvalid, cc_tdata[127:0], e[127:0]);
    else n_pass++;
    n_checks++;
    if (cc_tkeep !== 16'h0007 || cc_tdata[45:43] !== 3'b001)
      $display("FAIL timeout_status: tkeep=%h status=%b, required 0007/001", cc_tkeep, cc_tdata[45:43]);
    else n_pass++;
    done = 1'b1; rd_data = 32'hDEADBEEF;
    @(negedge user_clk);
    done = 1'b0;
    n_checks++;
    if (cc_tdata !== e || pulse_cnt - p0 !== 1)
      $display("FAIL timeout_late_done: got %h pulses=%0d, required %h pulses=1", cc_tdata[127:0], pulse_cnt - p0, e[127:0]);
    else n_pass++;
    accept_beat();
    rd_data = 32'h0;
  endtask

  task automatic test_timeout_boundary();
    logic [W-1:0] e;
    e = exp_cc(16'h0B0C, 8'h61, 3'd0, 3'd0, 3'b000, 1'b1, 32'hA5A55A5A);
    cq_set(16'h0B0C, 8'h61, 3'd0, 3'd0, 4'b1000, 2'b01, 8'h00);
    @(negedge user_clk);
    cq_tvalid = 1'b0;
    repeat (1023) @(negedge user_clk);
    n_checks++;
    if (cc_tvalid !== 1'b0) $display("FAIL boundary_pre: tvalid=%b, required 0", cc_tvalid);
    else n_pass++;
    done = 1'b1; rd_data = 32'hA5A55A5A;
    @(negedge user_clk);
    done = 1'b0; rd_data = 32'h0;
    n_checks++;
    if (cc_tvalid !== 1'b1 || cc_tdata !== e)
      $display("FAIL boundary_done_wins: tvalid=%b got %h, required 1 %h", cc_tvalid, cc_tdata[127:0], e[127:0]);
    else n_pass++;
    accept_beat();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] e;
    int p0;
    p0 = pulse_cnt;
    e = exp_cc(16'h0300, 8'h77, 3'd3, 3'b100, 3'b000, 1'b1, 32'h76543210);
    cq_set(16'h0300, 8'h77, 3'd3, 3'b100, 4'b1000, 2'b01, 8'h00);
    @(negedge user_clk);
    done = 1'b1; rd_data = 32'h76543210;
    @(negedge user_clk);
    done = 1'b0; rd_data = 32'h0;
    cq_set(16'h0400, 8'h88, 3'd5, 3'b001, 4'b1010, 2'b01, 8'h00);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (cc_tvalid !== 1'b1 || busy !== 1'b1 || cc_tdata !== e)
        $display("FAIL backpressure_hold[%0d]: tvalid=%b busy=%b got %h, required 1/1 %h", i, cc_tvalid, busy, cc_tdata[127:0], e[127:0]);
      else n_pass++;
      if (i == 4) done = 1'b1;
      if (i == 5) done = 1'b0;
      @(negedge user_clk);
    end
    cc_tready = 1'b1; cq_tvalid = 1'b0;
    @(negedge user_clk);
    cc_tready = 1'b0;
    repeat (3) @(negedge user_clk);
    n_checks++;
    if (busy !== 1'b0 || cc_tvalid !== 1'b0 || pulse_cnt - p0 !== 1)
      $display("FAIL backpressure_second_cq: busy=%b tvalid=%b pulses=%0d, required 0/0/1", busy, cc_tvalid, pulse_cnt - p0);
    else n_pass++;
  endtask

  task automatic test_same_cycle();
    logic [W-1:0] e;
    int p0;
    p0 = pulse_cnt;
    e = exp_cc(16'h0500, 8'h3C, 3'd7, 3'b011, 3'b000, 1'b1, 32'h0BADF00D);
    cq_set(16'h0500, 8'h3C, 3'd7, 3'b011, 4'b1000, 2'b01, 8'h00);
    done = 1'b1; rd_data = 32'h0BADF00D;
    @(negedge user_clk);
    done = 1'b0; rd_data = 32'h0; cq_tvalid = 1'b0;
    n_checks++;
    if (cc_tvalid !== 1'b1 || cc_tdata !== e)
      $display("FAIL same_cycle_tdata: tvalid=%b got %h, required 1 %h", cc_tvalid, cc_tdata[127:0], e[127:0]);
    else n_pass++;
    repeat (2) @(negedge user_clk);
    n_checks++;
    if (pulse_cnt - p0 !== 1) $display("FAIL same_cycle_pulse: got %0d pulses, required 1", pulse_cnt - p0);
    else n_pass++;
    accept_beat();
  endtask

  task automatic test_non_qualifying();
    logic [1:0] sels  [3];
    logic [7:0] funcs [3];
    logic [3:0] rtypes[3];
    int p0;
    sels   = '{2'b10, 2'b01, 2'b01};
    funcs  = '{8'h00, 8'h01, 8'h00};
    rtypes = '{4'b1000, 4'b1000, 4'b0000};
    for (int i = 0; i < 3; i++) begin
      p0 = pulse_cnt;
      cq_set(16'h0700, 8'h44, 3'd0, 3'd0, rtypes[i], sels[i], funcs[i]);
      done = 1'b1; rd_data = 32'hFFFF0000;
      repeat (4) @(negedge user_clk);
      n_checks++;
      if (busy !== 1'b0 || cc_tvalid !== 1'b0 || pulse_cnt - p0 !== 0)
        $display("FAIL nonqual[%0d]: busy=%b tvalid=%b pulses=%0d, required 0/0/0", i, busy, cc_tvalid, pulse_cnt - p0);
      else n_pass++;
      cq_tvalid = 1'b0; done = 1'b0; rd_data = 32'h0;
      @(negedge user_clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] e;
    cq_set(16'h0800, 8'h01, 3'd0, 3'd0, 4'b1000, 2'b01, 8'h00);
    @(negedge user_clk);
    cq_tvalid = 1'b0;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL rst_wait_pre: busy=%b, required 1", busy);
    else n_pass++;
    #2 user_reset_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || cc_tvalid !== 1'b0)
      $display("FAIL rst_wait_async: busy=%b tvalid=%b, required 0/0", busy, cc_tvalid);
    else n_pass++;
    @(negedge user_clk);
    user_reset_n = 1'b1;
    cq_set(16'h0900, 8'h02, 3'd0, 3'd0, 4'b1000, 2'b01, 8'h00);
    @(negedge user_clk);
    cq_tvalid = 1'b0; done = 1'b1; rd_data = 32'h99998888;
    @(negedge user_clk);
    done = 1'b0; rd_data = 32'h0;
    n_checks++;
    if (cc_tvalid !== 1'b1) $display("FAIL rst_send_pre: tvalid=%b, required 1", cc_tvalid);
    else n_pass++;
    #2 user_reset_n = 1'b0;
    #1;
    n_checks++;
    if (cc_tvalid !== 1'b0 || busy !== 1'b0 || cc_tdata !== '0)
      $display("FAIL rst_send_async: tvalid=%b busy=%b tdata=%h, required 0/0/0", cc_tvalid, busy, cc_tdata[127:0]);
    else n_pass++;
    @(negedge user_clk);
    user_reset_n = 1'b1;
    @(negedge user_clk);
    n_checks++;
    if (cc_tvalid !== 1'b0) $display("FAIL rst_no_replay: tvalid=%b, required 0", cc_tvalid);
    else n_pass++;
    e = exp_cc(16'h0600, 8'h5A, 3'd4, 3'b110, 3'b000, 1'b1, 32'h13579BDF);
    cq_set(16'h0600, 8'h5A, 3'd4, 3'b110, 4'b1000, 2'b01, 8'h00);
    @(negedge user_clk);
    cq_tvalid = 1'b0; done = 1'b1; rd_data = 32'h13579BDF;
    @(negedge user_clk);
    done = 1'b0; rd_data = 32'h0;
    n_checks++;
    if (cc_tvalid !== 1'b1 || cc_tdata !== e || cc_tkeep !== 16'h000F)
      $display("FAIL rst_after_read: tvalid=%b got %h tkeep=%h, required 1 %h 000f", cc_tvalid, cc_tdata[127:0], cc_tkeep, e[127:0]);
    else n_pass++;
    accept_beat();
    n_checks++;
    if (cc_tvalid !== 1'b0 || busy !== 1'b0)
      $display("FAIL rst_after_release: tvalid=%b busy=%b, required 0/0", cc_tvalid, busy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_timeout_boundary();
    test_backpressure();
    test_same_cycle();
    test_non_qualifying();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
